fifo_stream_reader: RTL and testbench

Read-side consumer of the synchronous FIFO. It pops words from the FIFO read port, whose data has 1-cycle read latency, and re-presents them on a valid/ready stream through a 2-entry output buffer. It also checks the FIFO's underflow flag against the reads it actually issued. It sits between the FIFO and any downstream sink, and is the reading end of the same FIFO interface the bench monitors.

---
 rtl/shared_pkg.sv | 6 +
 rtl/fifo_rd_skid.sv | 44 ++++
 rtl/fifo_stream_reader.sv | 67 ++++++
 tb/tb_fifo_stream_reader.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/shared_pkg.sv
// shared_pkg: reader state encoding, skid buffer depth and data word type
package shared_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} reader_state_e;
    localparam int SKID_DEPTH = 2;
    typedef logic [15:0] word_t;
endpackage

// File: rtl/fifo_rd_skid.sv
// fifo_rd_skid: 2-entry in-order buffer with registered head word
module fifo_rd_skid
    import shared_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  clear,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  pop,
    output logic [1:0]            occ,
    output logic [DATA_WIDTH-1:0] head
);
    logic [1:0]            occ_q, occ_d, base;
    logic [DATA_WIDTH-1:0] head_q, head_d, tail_q, tail_d;
    logic                  do_pop;
    // pop shifts the tail forward; push lands in the first free slot after the pop
    always_comb begin
        do_pop = pop && occ_q != 2'd0;
        base   = occ_q - {1'b0, do_pop};
        occ_d  = base + {1'b0, push};
        head_d = (do_pop && occ_q == 2'd2) ? tail_q : (push && base == 2'd0) ? din : head_q;
        tail_d = (push && base == 2'd1) ? din : tail_q;
    end
    // storage registers, cleared synchronously
    always_ff @(posedge clk) begin
        if (clear) begin
            occ_q  <= '0;
            head_q <= '0;
            tail_q <= '0;
        end else begin
            occ_q  <= occ_d;
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end
    // the read credit rule keeps a full buffer from ever receiving a word
    always_ff @(posedge clk) begin
        if (!clear && push) assert (occ_q != 2'(SKID_DEPTH));
    end
    assign occ  = occ_q;
    assign head = head_q;
endmodule

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: pops a 1-cycle-latency FIFO into a valid/ready stream
module fifo_stream_reader
    import shared_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data_out,
    input  logic                  fifo_underflow,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  m_ready,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  pop_count,
    output logic                  err_underflow
);
    reader_state_e        state_q;
    logic                 inflight_q, err_q, push, m_pop;
    logic [CNT_WIDTH-1:0] pop_count_q;
    logic [1:0]           occ;
    assign m_valid = occ != 2'd0;
    assign m_pop   = m_valid && m_ready;
    assign push    = inflight_q && !fifo_underflow;
    // a read is allowed only if the word can still fit once everything in flight lands
    assign fifo_rd_en = !rst && state_q == RUN && !fifo_empty &&
                        ({1'b0, occ} + {2'b0, inflight_q}) < (3'd2 + {2'b0, m_pop});
    fifo_rd_skid #(.DATA_WIDTH(DATA_WIDTH)) u_skid (
        .clk  (clk),
        .clear(rst),
        .push (push),
        .din  (fifo_data_out),
        .pop  (m_ready),
        .occ  (occ),
        .head (m_data)
    );
    // run/drain control: drain leaves to idle only once nothing is buffered or in flight
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else begin
            case (state_q)
                IDLE:    state_q <= enable ? RUN : IDLE;
                RUN:     state_q <= enable ? RUN : DRAIN;
                default: state_q <= enable ? RUN : (occ == 2'd0 && !inflight_q) ? IDLE : DRAIN;
            endcase
        end
    end
    // in-flight tracking, saturating pop counter and sticky underflow error
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_q  <= 1'b0;
            pop_count_q <= '0;
            err_q       <= 1'b0;
        end else begin
            inflight_q <= fifo_rd_en;
            if (push && pop_count_q != {CNT_WIDTH{1'b1}}) pop_count_q <= pop_count_q + 1'b1;
            err_q <= err_q | fifo_underflow;
        end
    end
    assign busy          = state_q != IDLE;
    assign pop_count     = pop_count_q;
    assign err_underflow = err_q;
endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb_fifo_stream_reader: randomized scoreboard bench with a queue-based FIFO model
module tb_fifo_stream_reader;
    typedef struct {
        logic [15:0] d;
        bit          uf;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        fifo_empty = 1'b1;
    logic [15:0] fifo_data_out = '0;
    logic        fifo_underflow = 1'b0;
    logic        fifo_rd_en, m_valid, busy, err_underflow;
    logic [15:0] m_data;
    logic        m_ready = 1'b0;
    logic [15:0] pop_count;

    logic        s_en = 1'b0;
    logic        s_rd_en, s_valid, s_busy, s_err;
    logic [15:0] s_data;
    logic [2:0]  s_cnt;

    ent_t        fq[$];
    logic [15:0] exp_q[$];
    int          compared = 0;
    int          mismatched = 0;
    int          loaded_ok = 0;
    int          rd_cnt = 0;
    bit          any_uf = 0;

    always #5 clk = ~clk;

    fifo_stream_reader #(.DATA_WIDTH(16), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .enable(enable), .fifo_empty(fifo_empty),
        .fifo_data_out(fifo_data_out), .fifo_underflow(fifo_underflow),
        .fifo_rd_en(fifo_rd_en), .m_valid(m_valid), .m_data(m_data),
        .m_ready(m_ready), .busy(busy), .pop_count(pop_count),
        .err_underflow(err_underflow)
    );

    fifo_stream_reader #(.DATA_WIDTH(16), .CNT_WIDTH(3)) u_sat (
        .clk(clk), .rst(rst), .enable(s_en), .fifo_empty(1'b0),
        .fifo_data_out(16'h5A5A), .fifo_underflow(1'b0),
        .fifo_rd_en(s_rd_en), .m_valid(s_valid), .m_data(s_data),
        .m_ready(1'b1), .busy(s_busy), .pop_count(s_cnt),
        .err_underflow(s_err)
    );

    // FIFO model: read data and underflow one cycle after rd_en, empty flag one cycle after a write
    always @(posedge clk) begin
        ent_t e;
        if (fifo_rd_en) begin
            if (fq.size() == 0) begin
                fifo_data_out  <= 16'hDEAD;
                fifo_underflow <= 1'b1;
            end else begin
                e = fq.pop_front();
                fifo_data_out  <= e.d;
                fifo_underflow <= e.uf;
            end
        end else fifo_underflow <= 1'b0;
        fifo_empty <= fq.size() == 0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        compared++;
        if (act !== exp_v) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    // monitor: output handshakes against the scoreboard, stall stability, no read while empty
    always @(negedge clk) begin
        if (!rst) begin
            if (fifo_rd_en) begin
                rd_cnt++;
                check("rd_en_while_empty", {31'b0, fifo_empty}, 0);
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_output: got %0h expected none", m_data);
                end else check("m_data", {16'b0, m_data}, {16'b0, exp_q.pop_front()});
            end else if (m_valid && exp_q.size() != 0) check("stall_head", {16'b0, m_data}, {16'b0, exp_q[0]});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [15:0] d, input bit uf);
        ent_t e;
        e.d  = d;
        e.uf = uf;
        fq.push_back(e);
        if (uf) any_uf = 1;
        else begin
            exp_q.push_back(d);
            loaded_ok++;
        end
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || fq.size() != 0 || m_valid) && n < 500) begin
            tick();
            n++;
        end
        repeat (2) tick();
        check({name, "_drain_timeout"}, {31'b0, n >= 500}, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        loaded_ok = 0;
        any_uf = 0;
    endtask

    initial begin
        int run, best, r0;
        repeat (3) tick();
        check("rst_m_valid", {31'b0, m_valid}, 0);
        check("rst_m_data", {16'b0, m_data}, 0);
        check("rst_pop_count", {16'b0, pop_count}, 0);
        check("rst_err", {31'b0, err_underflow}, 0);
        check("rst_busy", {31'b0, busy}, 0);
        check("rst_rd_en", {31'b0, fifo_rd_en}, 0);
        rst = 1'b0;
        tick();

        for (int i = 1; i <= 8; i++) load(16'(i), 0);
        m_ready = 1'b1;
        enable  = 1'b1;
        run = 0;
        best = 0;
        repeat (30) begin
            tick();
            if (m_valid) begin
                run++;
                if (run > best) best = run;
            end else run = 0;
        end
        check("stream_consecutive", best, 8);
        check("stream_pop_count", {16'b0, pop_count}, 8);
        check("stream_busy", {31'b0, busy}, 1);
        check("stream_left", exp_q.size(), 0);

        m_ready = 1'b0;
        r0 = rd_cnt;
        for (int i = 1; i <= 8; i++) load(16'(i), 0);
        repeat (10) tick();
        check("bp_reads", rd_cnt - r0, 2);
        check("bp_rd_en_low", {31'b0, fifo_rd_en}, 0);
        check("bp_head", {16'b0, m_data}, 16'h0001);
        m_ready = 1'b1;
        wait_drain("bp");
        check("bp_pop_count", {16'b0, pop_count}, 16);

        for (int i = 0; i < 6; i++) load(16'h0100 + 16'(i), 0);
        run = 0;
        while (!fifo_rd_en && run < 20) begin
            tick();
            run++;
        end
        check("drop_rd_seen", {31'b0, fifo_rd_en}, 1);
        enable = 1'b0;
        tick();
        r0 = rd_cnt;
        repeat (8) tick();
        check("drop_no_reads", rd_cnt - r0, 0);
        check("drop_idle", {31'b0, busy}, 0);
        check("drop_no_loss", exp_q.size(), fq.size());
        check("drop_pop_count", {16'b0, pop_count}, loaded_ok - fq.size());
        enable = 1'b1;
        wait_drain("drop");

        load(16'h1111, 0);
        load(16'hBEEF, 1);
        load(16'h2222, 0);
        wait_drain("uf");
        check("uf_err", {31'b0, err_underflow}, 1);
        check("uf_pop_count", {16'b0, pop_count}, loaded_ok);
        repeat (5) tick();
        check("uf_sticky", {31'b0, err_underflow}, 1);
        do_reset();
        check("uf_cleared", {31'b0, err_underflow}, 0);

        m_ready = 1'b0;
        for (int i = 0; i < 6; i++) load(16'h0A00 + 16'(i), 0);
        repeat (4) tick();
        rst = 1'b1;
        #1;
        check("mid_rst_rd_en", {31'b0, fifo_rd_en}, 0);
        enable = 1'b0;
        tick();
        exp_q.delete();
        fq.delete();
        check("mid_rst_valid", {31'b0, m_valid}, 0);
        check("mid_rst_pop_count", {16'b0, pop_count}, 0);
        check("mid_rst_busy", {31'b0, busy}, 0);
        rst = 1'b0;
        loaded_ok = 0;
        any_uf = 0;
        m_ready = 1'b1;
        repeat (4) tick();
        check("mid_rst_after_valid", {31'b0, m_valid}, 0);
        check("mid_rst_after_cnt", {16'b0, pop_count}, 0);

        enable = 1'b1;
        for (int c = 0; c < 600; c++) begin
            m_ready = ($urandom % 4) != 0;
            enable  = ($urandom % 16) != 0;
            if ($urandom % 3 == 0) load(16'($urandom), ($urandom % 10) == 0);
            tick();
        end
        enable  = 1'b1;
        m_ready = 1'b1;
        wait_drain("rand");
        check("rand_pop_count", {16'b0, pop_count}, loaded_ok);
        check("rand_err", {31'b0, err_underflow}, {31'b0, any_uf});

        s_en = 1'b1;
        repeat (14) tick();
        check("sat_pop_count", {29'b0, s_cnt}, 7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule
